fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Front-end redirect controller for the IF1 fetch stage. Arbitrates all PC-redirect sources (trap, branch mispredict, FENCE.I, WFI, IF2 predecode correction) into the single registered flush/flush-PC pair that drives IF1. Sequences the FENCE.I instruction-cache invalidate handshake and WFI sleep, holding fetch while either is in progress. Sits between the backend/IF2 and IF1; its hold output is ORed with the IF2 busy signal into IF1's stall input.

## Interface

- RESET_ADDR, 32'h00000000, PC presented on flush_pc_o during and after reset
- cpu_clk_i  in  1  core clock
- cpu_rst_i  in  1  reset; one clock; asynchronous, active-high
- trap_vld_i  in  1  trap/interrupt redirect request (1-cycle pulse)
- trap_pc_i  in  32  trap target
- mispred_vld_i  in  1  backend branch-mispredict redirect
- mispred_pc_i  in  32  corrected PC
- fencei_vld_i  in  1  FENCE.I retired
- fencei_pc_i  in  32  PC following FENCE.I
- wfi_vld_i  in  1  WFI retired
- wfi_pc_i  in  32  PC following WFI
- irq_pending_i  in  1  level; wakes from WFI
- predec_vld_i  in  1  IF2 predecode redirect
- predec_pc_i  in  32  predecode target
- icache_inv_req_o  out  1  invalidate request, held until ack
- icache_inv_ack_i  in  1  invalidate complete (1-cycle pulse)
- flush_o  out  1  to IF1 flush input
- flush_pc_o  out  32  to IF1 flush PC input; bits [1:0] always 0
- hold_o  out  1  freeze fetch (ORed into IF1 busy)
- state_o  out  2  FSM state: 0 RUN, 1 INVAL, 2 WFI
- redirect_cnt_o  out  32  count of flush_o pulses since reset

## Operation

- All outputs registered. Reset values: flush_o=1, flush_pc_o=RESET_ADDR, hold_o=0, icache_inv_req_o=0, state_o=RUN, redirect_cnt_o=0. flush_o stays 1 while reset asserted; drops on first clock after release.
- flush_pc_o = selected PC with bits [1:0] cleared.
- RUN, fixed priority: trap > mispred > fencei > wfi > predec. Winner produces flush_o=1, flush_pc_o=its PC next cycle; losers dropped (backend guarantees no conflicting retry needed).
- predec_vld_i ignored in any cycle where flush_o is 1 (stale IF2 contents) or any backend request is present.
- RUN + fencei wins: flush to fencei_pc, hold_o=1, icache_inv_req_o=1, go INVAL; resume_pc := fencei_pc.
- INVAL: hold_o=1; mispred, fencei, wfi, predec ignored. trap_vld_i overwrites resume_pc with trap_pc_i (no flush yet; handshake is never aborted). On icache_inv_ack_i: icache_inv_req_o=0, hold_o=0, flush_o=1 with resume_pc, go RUN. Trap and ack same cycle: trap_pc used.
- RUN + wfi wins: flush to wfi_pc, hold_o=1, go WFI.
- WFI: trap_vld_i → flush to trap_pc, hold_o=0, RUN (trap beats irq_pending_i same cycle). Else irq_pending_i=1 → hold_o=0, RUN, no flush. Other requests ignored.
- redirect_cnt_o increments on every cycle flush_o is 1 after reset release; wraps at 2^32.
- Reset asserted mid-INVAL/WFI: immediately return to reset values; icache_inv_req_o drops asynchronously.
- state_o encoding 3 unused; never reached.

## Timing

- Request sampled at edge N → flush_o/flush_pc_o valid during cycle N+1, exactly one cycle wide (unless new winner at N+1).
- hold_o asserts in the same cycle as the entry flush_o; deasserts in the cycle of the exit flush_o (INVAL) or the cycle after irq_pending_i sampled (WFI).
- icache_inv_req_o rises cycle after fencei sampled; falls cycle after ack sampled.
- Back-to-back RUN redirects on consecutive cycles each yield a flush_o pulse; flush_o may stay high continuously.

## Test plan

- Reset release with RESET_ADDR=32'h8000_0000 → flush_o=1, flush_pc_o=32'h8000_0000 during reset, 0 one cycle after; redirect_cnt_o=0.
- Same cycle trap_pc=0x100, mispred_pc=0x200, predec_pc=0x300 → single flush_o pulse, flush_pc_o=0x100, redirect_cnt_o +1.
- fencei_pc=0x40 → flush 0x40, hold_o=1, inv_req=1; ack after 5 cycles → next cycle flush 0x40, hold_o=0, inv_req=0, state RUN; cnt +2.
- FENCE.I pending, trap_pc=0x80 at cycle 2, ack at cycle 4 → no flush until ack; exit flush_pc_o=0x80.
- wfi_pc=0x1C → flush 0x1C, hold 1; irq_pending_i at cycle 10 → hold 0 next cycle, no flush; separately trap+irq same cycle → flush to trap_pc.
- predec_vld_i in cycle where flush_o=1 → ignored; predec_pc=0x203 alone in RUN → flush_pc_o=0x200.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect request / IF1 control bundle for fetch_redirect_ctrl
interface fetch_redirect_ctrl_if;
    logic        trap_vld_i;
    logic [31:0] trap_pc_i;
    logic        mispred_vld_i;
    logic [31:0] mispred_pc_i;
    logic        fencei_vld_i;
    logic [31:0] fencei_pc_i;
    logic        wfi_vld_i;
    logic [31:0] wfi_pc_i;
    logic        irq_pending_i;
    logic        predec_vld_i;
    logic [31:0] predec_pc_i;
    logic        icache_inv_req_o;
    logic        icache_inv_ack_i;
    logic        flush_o;
    logic [31:0] flush_pc_o;
    logic        hold_o;
    logic [1:0]  state_o;
    logic [31:0] redirect_cnt_o;

    modport master (
        output trap_vld_i, trap_pc_i, mispred_vld_i, mispred_pc_i,
               fencei_vld_i, fencei_pc_i, wfi_vld_i, wfi_pc_i,
               irq_pending_i, predec_vld_i, predec_pc_i, icache_inv_ack_i,
        input  icache_inv_req_o, flush_o, flush_pc_o, hold_o, state_o, redirect_cnt_o
    );

    modport slave (
        input  trap_vld_i, trap_pc_i, mispred_vld_i, mispred_pc_i,
               fencei_vld_i, fencei_pc_i, wfi_vld_i, wfi_pc_i,
               irq_pending_i, predec_vld_i, predec_pc_i, icache_inv_ack_i,
        output icache_inv_req_o, flush_o, flush_pc_o, hold_o, state_o, redirect_cnt_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - IF1 redirect arbiter with FENCE.I invalidate and WFI sequencing
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input logic                 cpu_clk_i,
    input logic                 cpu_rst_i,
    fetch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_INVAL = 2'd1,
        ST_WFI   = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = RESET_ADDR & ~32'h3;

    state_t      state_q, state_nxt;
    logic        flush_q, flush_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic        hold_q, hold_nxt;
    logic        inv_req_q, inv_req_nxt;
    logic [31:0] resume_q, resume_nxt;
    logic [31:0] cnt_q;

    // All outputs are registered alongside the state so IF1 sees glitch-free controls.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state_q   <= ST_RUN;
            flush_q   <= 1'b1;
            pc_q      <= RESET_PC;
            hold_q    <= 1'b0;
            inv_req_q <= 1'b0;
            resume_q  <= RESET_PC;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_nxt;
            flush_q   <= flush_nxt;
            pc_q      <= pc_nxt & ~32'h3;
            hold_q    <= hold_nxt;
            inv_req_q <= inv_req_nxt;
            resume_q  <= resume_nxt;
            cnt_q     <= cnt_q + {31'd0, flush_nxt};
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.trap_vld_i || bus.mispred_vld_i) state_nxt = ST_RUN;
                else if (bus.fencei_vld_i)               state_nxt = ST_INVAL;
                else if (bus.wfi_vld_i)                  state_nxt = ST_WFI;
            end
            ST_INVAL: if (bus.icache_inv_ack_i)                 state_nxt = ST_RUN;
            ST_WFI:   if (bus.trap_vld_i || bus.irq_pending_i)  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        flush_nxt   = 1'b0;
        pc_nxt      = pc_q;
        hold_nxt    = hold_q;
        inv_req_nxt = inv_req_q;
        resume_nxt  = resume_q;
        case (state_q)
            ST_INVAL: begin
                // A trap during the invalidate only retargets the eventual exit flush.
                if (bus.trap_vld_i) resume_nxt = bus.trap_pc_i;
                if (bus.icache_inv_ack_i) begin
                    flush_nxt   = 1'b1;
                    pc_nxt      = bus.trap_vld_i ? bus.trap_pc_i : resume_q;
                    hold_nxt    = 1'b0;
                    inv_req_nxt = 1'b0;
                end else begin
                    hold_nxt    = 1'b1;
                    inv_req_nxt = 1'b1;
                end
            end
            ST_WFI: begin
                if (bus.trap_vld_i) begin
                    flush_nxt = 1'b1;
                    pc_nxt    = bus.trap_pc_i;
                    hold_nxt  = 1'b0;
                end else if (bus.irq_pending_i) begin
                    hold_nxt  = 1'b0;
                end else begin
                    hold_nxt  = 1'b1;
                end
            end
            default: begin
                hold_nxt    = 1'b0;
                inv_req_nxt = 1'b0;
                if (bus.trap_vld_i) begin
                    flush_nxt = 1'b1;
                    pc_nxt    = bus.trap_pc_i;
                end else if (bus.mispred_vld_i) begin
                    flush_nxt = 1'b1;
                    pc_nxt    = bus.mispred_pc_i;
                end else if (bus.fencei_vld_i) begin
                    flush_nxt   = 1'b1;
                    pc_nxt      = bus.fencei_pc_i;
                    hold_nxt    = 1'b1;
                    inv_req_nxt = 1'b1;
                    resume_nxt  = bus.fencei_pc_i;
                end else if (bus.wfi_vld_i) begin
                    flush_nxt = 1'b1;
                    pc_nxt    = bus.wfi_pc_i;
                    hold_nxt  = 1'b1;
                end else if (bus.predec_vld_i && !flush_q) begin
                    // IF2 contents are stale while a flush is being applied.
                    flush_nxt = 1'b1;
                    pc_nxt    = bus.predec_pc_i;
                end
            end
        endcase
    end

    assign bus.flush_o          = flush_q;
    assign bus.flush_pc_o       = pc_q;
    assign bus.hold_o           = hold_q;
    assign bus.icache_inv_req_o = inv_req_q;
    assign bus.state_o          = state_q;
    assign bus.redirect_cnt_o   = cnt_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if bus();

    fetch_redirect_ctrl #(.RESET_ADDR(32'h8000_0000)) dut (
        .cpu_clk_i(clk),
        .cpu_rst_i(rst),
        .bus      (bus)
    );

    typedef struct {
        logic        flush;
        logic [31:0] pc;
        logic        hold;
        logic        req;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    logic [1:0]  m_st;
    logic        m_flush, m_hold, m_req;
    logic [31:0] m_pc, m_resume, m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.trap_vld_i = 0;    bus.trap_pc_i = '0;
        bus.mispred_vld_i = 0; bus.mispred_pc_i = '0;
        bus.fencei_vld_i = 0;  bus.fencei_pc_i = '0;
        bus.wfi_vld_i = 0;     bus.wfi_pc_i = '0;
        bus.irq_pending_i = 0;
        bus.predec_vld_i = 0;  bus.predec_pc_i = '0;
        bus.icache_inv_ack_i = 0;
    endtask

    task automatic model_reset();
        m_st = 2'd0; m_flush = 1; m_pc = 32'h8000_0000; m_hold = 0; m_req = 0;
        m_cnt = 0; m_resume = 32'h8000_0000;
    endtask

    task automatic model_step();
        logic f, h, r;
        logic [1:0] s;
        logic [31:0] p;
        exp_t e;
        f = 0; p = m_pc; s = m_st; h = m_hold; r = m_req;
        if (m_st == 2'd0) begin
            if (bus.trap_vld_i) begin f = 1; p = bus.trap_pc_i; end
            else if (bus.mispred_vld_i) begin f = 1; p = bus.mispred_pc_i; end
            else if (bus.fencei_vld_i) begin
                f = 1; p = bus.fencei_pc_i; h = 1; r = 1; s = 2'd1; m_resume = bus.fencei_pc_i;
            end
            else if (bus.wfi_vld_i) begin f = 1; p = bus.wfi_pc_i; h = 1; s = 2'd2; end
            else if (bus.predec_vld_i && !m_flush) begin f = 1; p = bus.predec_pc_i; end
        end else if (m_st == 2'd1) begin
            if (bus.icache_inv_ack_i) begin
                f = 1; p = bus.trap_vld_i ? bus.trap_pc_i : m_resume; h = 0; r = 0; s = 2'd0;
            end else if (bus.trap_vld_i) m_resume = bus.trap_pc_i;
        end else begin
            if (bus.trap_vld_i) begin f = 1; p = bus.trap_pc_i; h = 0; s = 2'd0; end
            else if (bus.irq_pending_i) begin h = 0; s = 2'd0; end
        end
        m_flush = f; m_pc = {p[31:2], 2'b00}; m_hold = h; m_req = r; m_st = s;
        if (f) m_cnt = m_cnt + 1;
        e.flush = m_flush; e.pc = m_pc; e.hold = m_hold; e.req = m_req; e.st = m_st; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Drive current inputs for one clock, then compare against the scoreboard head.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("flush", {31'd0, bus.flush_o}, {31'd0, e.flush});
        check_val("flush_pc", bus.flush_pc_o, e.pc);
        check_val("hold", {31'd0, bus.hold_o}, {31'd0, e.hold});
        check_val("inv_req", {31'd0, bus.icache_inv_req_o}, {31'd0, e.req});
        check_val("state", {30'd0, bus.state_o}, {30'd0, e.st});
        check_val("cnt", bus.redirect_cnt_o, e.cnt);
        clear_inputs();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_flush"}, {31'd0, bus.flush_o}, 32'd1);
        check_val({tag, "_pc"}, bus.flush_pc_o, 32'h8000_0000);
        check_val({tag, "_hold"}, {31'd0, bus.hold_o}, 32'd0);
        check_val({tag, "_req"}, {31'd0, bus.icache_inv_req_o}, 32'd0);
        check_val({tag, "_state"}, {30'd0, bus.state_o}, 32'd0);
        check_val({tag, "_cnt"}, bus.redirect_cnt_o, 32'd0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 0;
        cycle();
        check_val("rel_flush", {31'd0, bus.flush_o}, 32'd0);
        check_val("rel_cnt", bus.redirect_cnt_o, 32'd0);

        // Simultaneous trap/mispred/predec: trap wins.
        bus.trap_vld_i = 1; bus.trap_pc_i = 32'h100;
        bus.mispred_vld_i = 1; bus.mispred_pc_i = 32'h200;
        bus.predec_vld_i = 1; bus.predec_pc_i = 32'h300;
        cycle();
        check_val("prio_pc", bus.flush_pc_o, 32'h100);
        check_val("prio_cnt", bus.redirect_cnt_o, 32'd1);
        cycle();
        check_val("prio_once", {31'd0, bus.flush_o}, 32'd0);

        // FENCE.I with ack five cycles later.
        bus.fencei_vld_i = 1; bus.fencei_pc_i = 32'h40;
        cycle();
        check_val("fi_pc", bus.flush_pc_o, 32'h40);
        check_val("fi_hold", {31'd0, bus.hold_o}, 32'd1);
        check_val("fi_req", {31'd0, bus.icache_inv_req_o}, 32'd1);
        repeat (4) begin
            bus.mispred_vld_i = 1; bus.mispred_pc_i = 32'h999;
            cycle();
        end
        bus.icache_inv_ack_i = 1;
        cycle();
        check_val("fi_exit_pc", bus.flush_pc_o, 32'h40);
        check_val("fi_exit_hold", {31'd0, bus.hold_o}, 32'd0);
        check_val("fi_exit_cnt", bus.redirect_cnt_o, 32'd3);

        // Trap during invalidate retargets the exit flush.
        bus.fencei_vld_i = 1; bus.fencei_pc_i = 32'h48;
        cycle();
        cycle();
        bus.trap_vld_i = 1; bus.trap_pc_i = 32'h80;
        cycle();
        check_val("fi_trap_noflush", {31'd0, bus.flush_o}, 32'd0);
        cycle();
        bus.icache_inv_ack_i = 1;
        cycle();
        check_val("fi_trap_pc", bus.flush_pc_o, 32'h80);

        // Trap and ack in the same cycle.
        bus.fencei_vld_i = 1; bus.fencei_pc_i = 32'h50;
        cycle();
        bus.icache_inv_ack_i = 1; bus.trap_vld_i = 1; bus.trap_pc_i = 32'hC4;
        cycle();
        check_val("ack_trap_pc", bus.flush_pc_o, 32'hC4);

        // WFI woken by irq at cycle 10.
        bus.wfi_vld_i = 1; bus.wfi_pc_i = 32'h1C;
        cycle();
        check_val("wfi_pc", bus.flush_pc_o, 32'h1C);
        check_val("wfi_hold", {31'd0, bus.hold_o}, 32'd1);
        repeat (8) begin
            bus.predec_vld_i = 1; bus.predec_pc_i = 32'h444;
            cycle();
        end
        bus.irq_pending_i = 1;
        cycle();
        check_val("wake_hold", {31'd0, bus.hold_o}, 32'd0);
        check_val("wake_noflush", {31'd0, bus.flush_o}, 32'd0);

        // WFI with trap and irq together.
        bus.wfi_vld_i = 1; bus.wfi_pc_i = 32'h20;
        cycle();
        bus.trap_vld_i = 1; bus.trap_pc_i = 32'h600; bus.irq_pending_i = 1;
        cycle();
        check_val("wfi_trap_pc", bus.flush_pc_o, 32'h600);
        check_val("wfi_trap_flush", {31'd0, bus.flush_o}, 32'd1);

        // Predecode suppressed while flush_o is high, then accepted and aligned.
        bus.predec_vld_i = 1; bus.predec_pc_i = 32'h500;
        cycle();
        check_val("predec_stale", {31'd0, bus.flush_o}, 32'd0);
        bus.predec_vld_i = 1; bus.predec_pc_i = 32'h203;
        cycle();
        check_val("predec_pc", bus.flush_pc_o, 32'h200);

        // Back-to-back mispredicts keep flush_o high.
        for (int i = 0; i < 3; i++) begin
            bus.mispred_vld_i = 1; bus.mispred_pc_i = 32'h1000 + 32'(i * 16);
            bus.predec_vld_i = 1; bus.predec_pc_i = 32'h777;
            cycle();
        end

        // Asynchronous reset in the middle of an invalidate.
        bus.fencei_vld_i = 1; bus.fencei_pc_i = 32'h70;
        cycle();
        cycle();
        rst = 1;
        #2;
        check_reset_values("midrst");
        sb.delete();
        model_reset();
        rst = 0;
        cycle();

        for (int i = 0; i < 400; i++) begin
            bus.trap_vld_i = ($urandom_range(0, 7) == 0);    bus.trap_pc_i = $urandom;
            bus.mispred_vld_i = ($urandom_range(0, 5) == 0); bus.mispred_pc_i = $urandom;
            bus.fencei_vld_i = ($urandom_range(0, 7) == 0);  bus.fencei_pc_i = $urandom;
            bus.wfi_vld_i = ($urandom_range(0, 7) == 0);     bus.wfi_pc_i = $urandom;
            bus.irq_pending_i = ($urandom_range(0, 9) == 0);
            bus.predec_vld_i = ($urandom_range(0, 2) == 0);  bus.predec_pc_i = $urandom;
            bus.icache_inv_ack_i = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
